// File: rtl/priority_encoder_4_to_2_if.sv
// rtl/priority_encoder_4_to_2_if.sv - request/ack/encoded-output bundle for the priority encoder
interface priority_encoder_4_to_2_if;
  logic       enable;   // active-low enable
  logic [3:0] in;       // active-low request lines
  logic       ack;      // retires the presented code
  logic [1:0] out;      // encoded highest-priority pending index
  logic       valid_n;  // active-low valid for out
  logic [3:0] pending;  // sticky pending vector

  modport master (
    output enable,
    output in,
    output ack,
    input  out,
    input  valid_n,
    input  pending
  );

  modport slave (
    input  enable,
    input  in,
    input  ack,
    output out,
    output valid_n,
    output pending
  );
endinterface

// File: rtl/priority_encoder_4_to_2.sv
// rtl/priority_encoder_4_to_2.sv - registered active-low 4-to-2 priority encoder with sticky capture and ack
module priority_encoder_4_to_2 #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  priority_encoder_4_to_2_if.slave    bus
);

  logic [3:0] in_q;
  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [1:0] out_q;
  logic [1:0] out_d;
  logic       valid_n_q;
  logic       valid_n_d;
  logic [3:0] event_w;
  logic [3:0] clear_w;
  logic       ack_accepted_w;

  // Highest pending index in the configured direction; only meaningful when p != 0.
  function automatic logic [1:0] encode(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'b00;
    if (PRIORITY_HIGH) begin
      if      (p[3]) idx = 2'd3;
      else if (p[2]) idx = 2'd2;
      else if (p[1]) idx = 2'd1;
      else           idx = 2'd0;
    end else begin
      if      (p[0]) idx = 2'd0;
      else if (p[1]) idx = 2'd1;
      else if (p[2]) idx = 2'd2;
      else           idx = 2'd3;
    end
    return idx;
  endfunction

  // Next-state: falling-edge capture, ack retirement of the registered index, output encode.
  always_comb begin
    event_w        = in_q & ~bus.in & {4{~bus.enable}};
    // Ack retires against what the consumer actually saw, i.e. the registered out/valid_n.
    ack_accepted_w = bus.ack & ~valid_n_q;
    clear_w        = 4'b0000;
    if (ack_accepted_w) begin
      clear_w[out_q] = 1'b1;
    end
    // A new event on the index being retired wins over the clear.
    pending_d      = event_w | (pending_q & ~clear_w);
    // Encoding pending_d rather than pending_q gives single-cycle latency on events and acks.
    out_d          = (|pending_d) ? encode(pending_d) : out_q;
    valid_n_d      = ~(~bus.enable & (|pending_d));
  end

  // State registers with synchronous active-high reset; reset discards same-edge events and acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q      <= 4'b1111;
      pending_q <= 4'b0000;
      out_q     <= 2'b00;
      valid_n_q <= 1'b1;
    end else begin
      in_q      <= bus.in;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_n_q <= valid_n_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid_n = valid_n_q;
  assign bus.pending = pending_q;

endmodule

// File: doc/priority_encoder_4_to_2.md
# priority_encoder_4_to_2

Registered, active-low 4-to-2 priority encoder with sticky request capture and an acknowledge handshake. It is the encode side of the active-low 2-to-4 decoder: it takes four active-low request lines (one-hot-low select lines or interrupt lines), latches each falling edge as a pending event, and presents the highest-priority pending index as a 2-bit code with an active-low valid. A consumer retires each presented event with a one-cycle `ack`.

## Interface
- `PRIORITY_HIGH`, default 1: 1 = index 3 highest priority, 0 downward; 0 = index 0 highest priority, 3 downward.

- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  active-low enable; 1 = capture blocked and `valid_n` forced 1.
- `in`  in  4  active-low request lines, synchronous to `clk`.
- `ack`  in  1  active-high, one-cycle pulse; retires the currently presented code.
- `out`  out  2  encoded index of the highest-priority pending request.
- `valid_n`  out  1  active-low; 0 = `out` is a live pending index.
- `pending`  out  4  active-high pending vector, for debug and status.

## Operation
- Internal state:
  - `in_q[3:0]` holds the previous sample of `in`.
  - `pending[3:0]` is one sticky bit per line. Each bit has two states: IDLE and PENDING.
  - The output register holds `out` and `valid_n`. It has two states: IDLE (`valid_n`=1) and PRESENTING (`valid_n`=0).
- Event on line i when `in_q[i]`=1, `in[i]`=0 and `enable`=0 at a rising edge (a falling edge of the request line).
  - A line held low produces exactly one event. It must return high before it can trigger again.
  - While `enable`=1, `in_q` still tracks `in`, but events are discarded. They are never replayed later.
- Ack is accepted when `ack`=1 and the registered `valid_n`=0. It clears `pending[out]` using the registered `out`.
  - Ack with `valid_n`=1 is ignored.
  - Ack is accepted even if `enable` rises in the same cycle.
- Next-state rule for each bit: `pending_next[i]` = event[i] | (`pending[i]` & ~(ack accepted & `out`==i)).
  - If an event and an ack clear hit the same index in the same cycle, the set wins. The new event is not lost.
- Output register is computed from `pending_next`, not from `pending`:
  - `out` <= priority encode of `pending_next` per `PRIORITY_HIGH`.
  - `valid_n` <= ~(~`enable` & |`pending_next`).
  - When `pending_next`=0, `out` holds its previous value.
- Preemption: a higher-priority event arriving while a lower index is presented replaces `out` on the next edge. The lower index stays pending.
- Reset values: `in_q`=4'b1111, `pending`=4'b0000, `out`=2'b00, `valid_n`=1.
  - Because `in_q` resets to 1, a line already low when reset deasserts yields an event on the first edge with `enable`=0.
- Reset asserted mid-operation clears all pending events and ignores `ack` and `in` on that edge.

## Timing
- Latency is 1 cycle. An event sampled at edge N shows `pending[i]`=1 and the updated `out`/`valid_n` after edge N.
- Ack accepted at edge N: after edge N, `out` shows the next-priority pending index, or `valid_n`=1 if none remain.
  - Back-to-back acks every cycle therefore drain one event per cycle with no stale re-ack.
- `enable` rising at edge N: `valid_n`=1 after edge N, and `pending` is retained.
- `enable` falling at edge N: `valid_n` reflects `pending` after edge N.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then `enable`=0 and `in`=4'b1111 for 5 cycles: `valid_n`=1, `pending`=0000, `out`=00 throughout.
- Drive `in`=4'b1011 (line 2 low) at edge N: after N, `pending`=0100, `out`=10, `valid_n`=0. Hold `in` low for 10 cycles and ack once: `valid_n`=1, and no re-trigger occurs while the line stays low.
- With `PRIORITY_HIGH`=1, drive `in`=4'b0110 in one cycle (lines 0 and 3 low): `out`=11. Ack: `out`=00 next cycle. Ack again: `valid_n`=1. Repeat with `PRIORITY_HIGH`=0: the order is 00, then 11.
- Line 1 presented; then line 1 goes high and falls again in the exact cycle `ack` is accepted: `pending[1]` stays 1 and `out`=01, `valid_n`=0 the next cycle.
- Set `enable`=1, pulse line 0 low for 1 cycle, then set `enable`=0: no event, `valid_n`=1. With line 3 pending, set `enable`=1: `valid_n`=1 and `pending`=1000. Set `enable`=0: `out`=11, `valid_n`=0.
- Line 2 pending, assert `reset` for 1 cycle together with `ack`=1 and a line 0 falling edge: after the edge, `pending`=0000, `valid_n`=1, `out`=00.
